// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between two requesters
//            (0 = execute stage, 1 = address/branch unit). Round-robin
//            arbitration, registered ALU drive, registered result returned
//            over a per-requester valid/ready response channel.
// Ports    : CLOCK_50, RESET_N (async, active-low)
//            req{0,1}_valid/ready/opcode/a/b : request channels
//            rsp{0,1}_valid/ready, rsp_result : response channels
//            alu_input_a/b, alu_opcode -> ALU ; alu_output <- ALU
//            busy : not idle ; ops_done : completed responses (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [OPCODE_WIDTH-1:0] req0_opcode,
    input  logic [DATA_WIDTH-1:0]   req0_a,
    input  logic [DATA_WIDTH-1:0]   req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [OPCODE_WIDTH-1:0] req1_opcode,
    input  logic [DATA_WIDTH-1:0]   req1_a,
    input  logic [DATA_WIDTH-1:0]   req1_b,
    output logic                    rsp0_valid,
    input  logic                    rsp0_ready,
    output logic                    rsp1_valid,
    input  logic                    rsp1_ready,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic [DATA_WIDTH-1:0]   alu_input_a,
    output logic [DATA_WIDTH-1:0]   alu_input_b,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    input  logic [DATA_WIDTH-1:0]   alu_output,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    ops_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic                    r_ptr;
    logic                    r_owner;
    logic [DATA_WIDTH-1:0]   r_alu_a;
    logic [DATA_WIDTH-1:0]   r_alu_b;
    logic [OPCODE_WIDTH-1:0] r_alu_op;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [CNT_WIDTH-1:0]    r_ops_done;

    logic                    w_grant0;
    logic                    w_grant1;
    logic                    w_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and grant decode. Grants exist only in IDLE; a lone valid
    // requester always wins, the pointer only breaks ties. Only the
    // owner's rsp_ready can complete a HOLD, so the other channel's ready
    // never reaches the request side.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_done       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                w_grant0 = req0_valid && (!req1_valid || !r_ptr);
                w_grant1 = req1_valid && (!req0_valid ||  r_ptr);
                if (w_grant0 || w_grant1) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                w_done = r_owner ? rsp1_ready : rsp0_ready;
                if (w_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ptr      <= 1'b0;
            r_owner    <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_result   <= '0;
            r_ops_done <= '0;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_alu_a  <= w_grant1 ? req1_a      : req0_a;
                r_alu_b  <= w_grant1 ? req1_b      : req0_b;
                r_alu_op <= w_grant1 ? req1_opcode : req0_opcode;
                r_owner  <= w_grant1;
                // Pointer moves to the requester that lost this grant.
                r_ptr    <= w_grant0;
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_output;
            end
            if (w_done) begin
                r_ops_done <= r_ops_done + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign rsp0_valid  = (r_state == S_HOLD) && !r_owner;
    assign rsp1_valid  = (r_state == S_HOLD) &&  r_owner;
    assign rsp_result  = r_result;
    assign alu_input_a = r_alu_a;
    assign alu_input_b = r_alu_b;
    assign alu_opcode  = r_alu_op;
    assign busy        = (r_state != S_IDLE);
    assign ops_done    = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. A cycle-level reference
//            model predicts grants, response timing and ops_done; grants push
//            expected results into a scoreboard queue that a monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int CW = 4;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N  = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [OW-1:0] req0_opcode = '0, req1_opcode = '0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic [DW-1:0] alu_input_a, alu_input_b, alu_output;
    logic [OW-1:0] alu_opcode;
    logic          busy;
    logic [CW-1:0] ops_done;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [DW-1:0] ref_alu(input logic [OW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_output = ref_alu(alu_opcode, alu_input_a, alu_input_b);

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .alu_input_a(alu_input_a), .alu_input_b(alu_input_b), .alu_opcode(alu_opcode),
        .alu_output(alu_output), .busy(busy), .ops_done(ops_done)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one operation in flight at a time; a response is
    // visible from the second edge after its grant until the owner takes it.
    // ------------------------------------------------------------------
    typedef struct {
        logic          id;
        logic [DW-1:0] res;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] obs_q[$];
    bit            m_inflight = 1'b0;
    bit            m_owner    = 1'b0;
    bit            m_ptr      = 1'b0;
    int            m_age      = 0;
    logic [CW-1:0] m_ops      = '0;

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            m_inflight = 1'b0;
            m_owner    = 1'b0;
            m_ptr      = 1'b0;
            m_age      = 0;
            m_ops      = '0;
            exp_q.delete();
        end else if (!m_inflight) begin
            if (req0_valid || req1_valid) begin
                exp_t e;
                bit   w;
                w     = (req0_valid && req1_valid) ? m_ptr : req1_valid;
                e.id  = w;
                e.res = w ? ref_alu(req1_opcode, req1_a, req1_b)
                          : ref_alu(req0_opcode, req0_a, req0_b);
                exp_q.push_back(e);
                m_ptr      = !w;
                m_owner    = w;
                m_inflight = 1'b1;
                m_age      = 0;
            end
        end else if (m_age >= 1 && (m_owner ? rsp1_ready : rsp0_ready)) begin
            m_inflight = 1'b0;
            m_ops      = m_ops + 1'b1;
        end else begin
            m_age = m_age + 1;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: checks control outputs against the model and drains the
    // scoreboard whenever a response is presented.
    // ------------------------------------------------------------------
    always @(negedge CLOCK_50) begin
        if (RESET_N === 1'b1) begin
            check("req0_ready", req0_ready, !m_inflight && req0_valid && (!req1_valid || !m_ptr));
            check("req1_ready", req1_ready, !m_inflight && req1_valid && (!req0_valid ||  m_ptr));
            check("busy", busy, m_inflight);
            check("ops_done", ops_done, m_ops);
            check("rsp0_valid", rsp0_valid, m_inflight && m_age >= 1 && !m_owner);
            check("rsp1_valid", rsp1_valid, m_inflight && m_age >= 1 &&  m_owner);
            if (rsp0_valid || rsp1_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got result %0h want no response (t=%0t)", rsp_result, $time);
                end else begin
                    check("rsp_owner", rsp1_valid, exp_q[0].id);
                    check("rsp_result", rsp_result, exp_q[0].res);
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        obs_q.push_back(rsp_result);
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    // One random stimulus cycle, entered and left at posedge+1. A request
    // is only replaced once it has been accepted.
    task automatic drive_cycle(input int pv, input int pr);
        bit a0, a1;
        @(negedge CLOCK_50);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge CLOCK_50);
        #1;
        if (!req0_valid || a0) begin
            req0_valid  = ($urandom_range(0, 99) < pv);
            req0_opcode = OW'($urandom_range(0, 2));
            req0_a      = $urandom;
            req0_b      = $urandom;
        end
        if (!req1_valid || a1) begin
            req1_valid  = ($urandom_range(0, 99) < pv);
            req1_opcode = OW'($urandom_range(0, 2));
            req1_a      = $urandom;
            req1_b      = $urandom;
        end
        rsp0_ready = ($urandom_range(0, 99) < pr);
        rsp1_ready = ($urandom_range(0, 99) < pr);
    endtask

    initial begin
        int base;
        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1 RESET_N = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ops", ops_done, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);

        // Lone requester 1: 5 + 7
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_opcode = 4'h0; req1_a = 5; req1_b = 7;
        #1;
        check("t1_req1_ready", req1_ready, 1);
        check("t1_req0_ready", req0_ready, 0);
        @(posedge CLOCK_50); #1;
        req1_valid = 1'b0;
        check("t1_exec_rsp1_valid", rsp1_valid, 0);
        @(posedge CLOCK_50); #1;
        check("t1_rsp1_valid", rsp1_valid, 1);
        check("t1_result", rsp_result, 12);
        check("t1_rsp0_valid", rsp0_valid, 0);
        @(posedge CLOCK_50); #1;
        check("t1_busy_after", busy, 0);
        check("t1_ops", ops_done, 1);

        // Both requesters continuously valid: alternating grants
        obs_q.delete();
        req0_valid = 1'b1; req0_opcode = 4'h1; req0_a = 10; req0_b = 3;
        req1_valid = 1'b1; req1_opcode = 4'h0; req1_a = 1;  req1_b = 1;
        repeat (12) @(posedge CLOCK_50);
        #1;
        check("t2_ops", ops_done, 5);
        check("t2_count", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            check("t2_res0", obs_q[0], 7);
            check("t2_res1", obs_q[1], 2);
            check("t2_res2", obs_q[2], 7);
            check("t2_res3", obs_q[3], 2);
        end

        // Backpressure on owner 0 with the wrong channel ready
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        req0_valid = 1'b0;
        @(posedge CLOCK_50); #1;
        check("t3_rsp0_valid", rsp0_valid, 1);
        check("t3_result", rsp_result, 7);
        repeat (5) begin
            @(posedge CLOCK_50); #1;
            check("t3_hold_valid", rsp0_valid, 1);
            check("t3_hold_result", rsp_result, 7);
            check("t3_hold_req1_ready", req1_ready, 0);
            check("t3_hold_busy", busy, 1);
        end
        rsp0_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        check("t3_idle", busy, 0);
        check("t3_ops", ops_done, 6);
        check("t3_req1_ready", req1_ready, 1);
        @(posedge CLOCK_50); #1;
        req1_valid = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("t3_ops_after", ops_done, 7);

        // Asynchronous reset while in EXEC
        req0_valid = 1'b1; req0_opcode = 4'h0; req0_a = 2; req0_b = 3;
        @(posedge CLOCK_50); #1;
        req0_valid = 1'b0;
        check("t4_exec_busy", busy, 1);
        #2 RESET_N = 1'b0;
        #1;
        check("t4_async_busy", busy, 0);
        check("t4_async_rsp0", rsp0_valid, 0);
        check("t4_async_rsp1", rsp1_valid, 0);
        req0_valid = 1'b1; req0_opcode = 4'h1; req0_a = 9; req0_b = 4;
        req1_valid = 1'b1; req1_opcode = 4'h0; req1_a = 6; req1_b = 6;
        @(posedge CLOCK_50); #1;
        RESET_N = 1'b1;
        #1;
        check("t4_req0_ready", req0_ready, 1);
        check("t4_req1_ready", req1_ready, 0);
        check("t4_ops", ops_done, 0);

        // Randomised traffic with random backpressure
        repeat (1500) drive_cycle(55, 65);

        // Counter wrap: 2^CW completions from reset
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge CLOCK_50); #1;
        RESET_N = 1'b0;
        @(posedge CLOCK_50); #1;
        RESET_N = 1'b1;
        base = n_pop;
        for (int i = 0; i < 300; i++) begin
            if (n_pop - base >= (1 << CW)) break;
            drive_cycle(100, 100);
        end
        check("wrap_completions", n_pop - base, 1 << CW);
        check("wrap_ops", ops_done, 0);

        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
